// File: rtl/modport_stack.sv
// Slave side of the ForthSuper data-stack port: LIFO with a registered TOS,
// a register-file body read combinationally at NOS, and overflow/underflow pulses.
module modport_stack #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 op,
    input  logic [DW-1:0]              vi,
    output logic [DW-1:0]              s,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       udf
);

    localparam int AW      = $clog2(DEPTH);
    localparam int DEPTH_W = AW + 1;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_READ = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    logic [DW-1:0]      body [DEPTH];
    logic [DW-1:0]      s_next;
    logic [DEPTH_W-1:0] depth_next;
    logic               ovf_next;
    logic               udf_next;
    logic               wr_en;
    logic [AW-1:0]      top_idx;
    logic [AW-1:0]      nos_idx;
    op_e                op_dec;

    assign op_dec = op_e'(op);
    assign empty  = (depth == '0);
    assign full   = (depth == DEPTH_W'(DEPTH));

    // Body holds cells below TOS: slot depth-1 receives the old TOS on push,
    // slot depth-2 is the next-on-stack that becomes TOS on pop.
    assign top_idx = depth[AW-1:0] - 1'b1;
    assign nos_idx = depth[AW-1:0] - AW'(2);

    always_comb begin
        s_next     = s;
        depth_next = depth;
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        wr_en      = 1'b0;
        if (en) begin
            case (op_dec)
                OP_PUSH: begin
                    if (full) begin
                        ovf_next = 1'b1;
                    end else begin
                        wr_en      = !empty;
                        s_next     = vi;
                        depth_next = depth + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        udf_next = 1'b1;
                    end else begin
                        s_next     = (depth >= DEPTH_W'(2)) ? body[nos_idx] : '0;
                        depth_next = depth - 1'b1;
                    end
                end
                OP_READ: ;
                OP_NOP:  ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s     <= '0;
            depth <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            s     <= s_next;
            depth <= depth_next;
            ovf   <= ovf_next;
            udf   <= udf_next;
        end
    end

    // Body is not cleared by reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            body[top_idx] <= s;
        end
    end

endmodule

// File: tb/tb_modport_stack.sv
// Self-checking bench for modport_stack: directed vector table, hand-written
// full/overflow and async-reset sequences, then random ops against a queue model.
module tb_modport_stack;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int DWD   = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst;
    logic           en;
    logic [1:0]     op;
    logic [DW-1:0]  vi;
    logic [DW-1:0]  s;
    logic [DWD-1:0] depth;
    logic           empty;
    logic           full;
    logic           ovf;
    logic           udf;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q [$];
    logic          m_ovf;
    logic          m_udf;

    modport_stack #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .op    (op),
        .vi    (vi),
        .s     (s),
        .depth (depth),
        .empty (empty),
        .full  (full),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [31:0] vi;
        logic [31:0] s;
        int          depth;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        udf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model_tos();
        return (model_q.size() == 0) ? 32'h0 : model_q[$];
    endfunction

    // Drive one op, advance one clock, update the reference queue.
    task automatic step(input logic e, input logic [1:0] o, input logic [31:0] v);
        en = e;
        op = o;
        vi = v;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        if (e && o == 2'b00) begin
            if (model_q.size() == DEPTH) m_ovf = 1'b1;
            else model_q.push_back(v);
        end else if (e && o == 2'b01) begin
            if (model_q.size() == 0) m_udf = 1'b1;
            else void'(model_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".s"},     s,     model_tos());
        check({tag, ".depth"}, 32'(depth), 32'(model_q.size()));
        check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, ".udf"},   32'(udf),   32'(m_udf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    vec_t vecs [16];

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        op  = 2'b11;
        vi  = '0;
        do_reset();

        check("reset.s",     s,          32'h0);
        check("reset.depth", 32'(depth), 32'd0);
        check("reset.empty", 32'(empty), 32'd1);
        check("reset.full",  32'(full),  32'd0);
        check("reset.ovf",   32'(ovf),   32'd0);
        check("reset.udf",   32'(udf),   32'd0);

        //          en    op     vi        s        d  emp   full  ovf   udf
        vecs[0]  = '{1'b1, 2'b00, 32'h11,  32'h11,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b00, 32'h22,  32'h22,  2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b00, 32'h33,  32'h33,  3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 32'h0,   32'h33,  3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 32'h0,   32'h22,  2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 32'h0,   32'h11,  1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b01, 32'h0,   32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 32'h0,   32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 2'b11, 32'h0,   32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 32'h55,  32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b00, 32'h5,   32'h5,   1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 2'b00, 32'hA,   32'hA,   2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 2'b01, 32'h0,   32'h5,   1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'b00, 32'hA,   32'hA,   2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 2'b01, 32'h0,   32'h5,   1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 2'b01, 32'h0,   32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].en, vecs[i].op, vecs[i].vi);
            check($sformatf("vec%0d.s", i),     s,          vecs[i].s);
            check($sformatf("vec%0d.depth", i), 32'(depth), 32'(vecs[i].depth));
            check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d.full", i),  32'(full),  32'(vecs[i].full));
            check($sformatf("vec%0d.ovf", i),   32'(ovf),   32'(vecs[i].ovf));
            check($sformatf("vec%0d.udf", i),   32'(udf),   32'(vecs[i].udf));
        end

        // Fill to DEPTH, overflow attempt, then drain in LIFO order.
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 2'b00, 32'(i));
            check($sformatf("fill%0d.s", i), s, 32'(i));
        end
        check("fill.full",  32'(full),  32'd1);
        check("fill.depth", 32'(depth), 32'(DEPTH));
        step(1'b1, 2'b00, 32'hDEAD);
        check("ovf.pulse", 32'(ovf),   32'd1);
        check("ovf.udf",   32'(udf),   32'd0);
        check("ovf.s",     s,          32'(DEPTH));
        check("ovf.depth", 32'(depth), 32'(DEPTH));
        step(1'b1, 2'b11, 32'h0);
        check("ovf.clear", 32'(ovf), 32'd0);
        for (int i = DEPTH; i >= 1; i--) begin
            check($sformatf("drain%0d.tos", i), s, 32'(i));
            step(1'b1, 2'b01, 32'h0);
        end
        check("drain.s",     s,          32'h0);
        check("drain.empty", 32'(empty), 32'd1);

        // Async reset in the middle of a PUSH cycle with depth=5.
        for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 32'h100 + 32'(i));
        check("pre_rst.depth", 32'(depth), 32'd5);
        en = 1'b1;
        op = 2'b00;
        vi = 32'h99;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.s",     s,          32'h0);
        check("async_rst.depth", 32'(depth), 32'd0);
        check("async_rst.empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold.depth", 32'(depth), 32'd0);
        rst = 1'b0;
        model_q.delete();
        step(1'b1, 2'b00, 32'h7);
        check("post_rst.s",     s,          32'h7);
        check("post_rst.depth", 32'(depth), 32'd1);

        // Random ops against the queue model; push-biased phases reach full.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [1:0]  o;
            r = $urandom_range(0, 99);
            if ((i / 500) % 2 == 0) o = (r < 60) ? 2'b00 : (r < 85) ? 2'b01 : 2'(r[0] ? 2'b10 : 2'b11);
            else                    o = (r < 30) ? 2'b00 : (r < 85) ? 2'b01 : 2'(r[0] ? 2'b10 : 2'b11);
            step(($urandom_range(0, 9) != 0), o, $urandom);
            check_model($sformatf("rnd%0d", i));
            if (ovf && udf) check("rnd.exclusive", 32'd1, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
